// File: rtl/decoder_pkg.sv
// Shared encodings and helpers for the scanning one-hot decoder.
package decoder_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_ONCE   = 2'b11;

    // Widest supported output (N <= 8); callers size-cast down to 2^N.
    localparam int MAX_OUT = 256;

    typedef enum logic [2:0] {
        IDLE,
        DIRECT,
        SCAN,
        ONCE,
        FIN
    } state_t;

    function automatic logic [MAX_OUT-1:0] onehot(input int unsigned code);
        return MAX_OUT'(1) << code;
    endfunction

    // FIN still belongs to mode 11 so a held mode never restarts the pass.
    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            IDLE:    return MODE_OFF;
            DIRECT:  return MODE_DIRECT;
            SCAN:    return MODE_SCAN;
            default: return MODE_ONCE;
        endcase
    endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// Per-step dwell counter: o_step is high in the last cycle of a step (count == latched dwell).
// Load restarts at 0 and samples i_dwell; hold freezes; otherwise counts, re-sampling dwell at each wrap.
module decoder_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_hold,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_step
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_lim;

    assign o_step = (r_cnt == r_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lim <= '0;
        end else if (i_load || (!i_hold && o_step)) begin
            r_cnt <= '0;
            r_lim <= i_dwell;
        end else if (!i_hold) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct load and timed (continuous or single-pass) scan.
// One-cycle latency from edge to y; no backpressure, e=0 gates outputs and freezes all state.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_e,
    input  logic [1:0]         i_mode,
    input  logic [N-1:0]       i_a,
    input  logic               i_valid,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [(1<<N)-1:0]  o_y,
    output logic [N-1:0]       o_code,
    output logic               o_wrap,
    output logic               o_done,
    output logic               o_busy
);

    localparam int OUT_W = 1 << N;

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_idx;
    logic [OUT_W-1:0] r_y;
    logic [N-1:0]     r_code;
    logic             r_wrap;
    logic             r_done;

    logic [N-1:0]     w_idx_nxt;
    logic [N-1:0]     w_idx_inc;
    logic [OUT_W-1:0] w_y_nxt;
    logic [N-1:0]     w_code_nxt;
    logic             w_wrap_nxt;
    logic             w_done_nxt;

    logic w_mode_chg;
    logic w_scanning;
    logic w_run;
    logic w_hold;
    logic w_load;
    logic w_tstep;
    logic w_step;
    logic w_last;

    assign w_mode_chg = (i_mode != mode_of(r_state));
    assign w_scanning = (r_state == SCAN) || (r_state == ONCE);
    assign w_run      = i_e && !w_mode_chg && w_scanning;
    assign w_hold     = !w_run;
    assign w_load     = i_e && w_mode_chg;
    assign w_step     = w_run && w_tstep;
    assign w_last     = (r_idx == {N{1'b1}});
    assign w_idx_inc  = r_idx + 1'b1;

    decoder_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_hold  (w_hold),
        .i_dwell (i_dwell),
        .o_step  (w_tstep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_e) begin
            if (w_mode_chg) begin
                case (i_mode)
                    MODE_DIRECT: w_next_state = DIRECT;
                    MODE_SCAN:   w_next_state = SCAN;
                    MODE_ONCE:   w_next_state = ONCE;
                    default:     w_next_state = IDLE;
                endcase
            end else if (r_state == ONCE && w_step && w_last) begin
                w_next_state = FIN;
            end
        end
    end

    // A mode change outranks any step boundary or load in the same cycle.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_y_nxt    = r_y;
        w_code_nxt = r_code;
        w_wrap_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (i_e) begin
            if (w_mode_chg) begin
                w_idx_nxt  = '0;
                w_code_nxt = '0;
                w_y_nxt    = (i_mode == MODE_SCAN || i_mode == MODE_ONCE) ? OUT_W'(1) : '0;
            end else begin
                case (r_state)
                    DIRECT: begin
                        if (i_valid) begin
                            w_y_nxt    = OUT_W'(onehot(32'(i_a)));
                            w_code_nxt = i_a;
                        end
                    end
                    SCAN, ONCE: begin
                        if (w_step) begin
                            if (r_state == ONCE && w_last) begin
                                w_idx_nxt  = '0;
                                w_y_nxt    = '0;
                                w_code_nxt = '0;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_idx_nxt  = w_idx_inc;
                                w_y_nxt    = OUT_W'(onehot(32'(w_idx_inc)));
                                w_code_nxt = w_idx_inc;
                                w_wrap_nxt = w_last;
                            end
                        end
                    end
                    default: begin
                        w_y_nxt    = '0;
                        w_code_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_y    <= '0;
            r_code <= '0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_y    <= w_y_nxt;
            r_code <= w_code_nxt;
            r_wrap <= w_wrap_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign o_y    = i_e ? r_y : '0;
    assign o_code = r_code;
    assign o_wrap = i_e && r_wrap;
    assign o_done = i_e && r_done;
    assign o_busy = i_e && w_scanning;

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 1x2/2x4 combinational decoders.
- Adds an enable, a direct-load mode, and a timed scan mode in which a one-hot walks across all outputs.
- Scan runs either continuously or for a single pass.
- Used for digit/row strobing, chip-select generation and LED walking in the bootcamp designs.

Parameters:
- N, 2, input code width; output width is 2^N (N >= 1).
- DWELL_W, 8, width of the dwell (cycles-per-step) control.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- e  input  1  enable; when low, y is forced to 0 and all internal state freezes.
- mode  input  2  00 OFF, 01 DIRECT, 10 SCAN, 11 SCAN_ONCE.
- a  input  N  code to decode in DIRECT mode.
- valid  input  1  load strobe for a in DIRECT mode.
- dwell  input  DWELL_W  extra cycles per scan step; each step lasts dwell+1 cycles.
- y  output  2^N  registered one-hot (or all-zero) output.
- code  output  N  binary index of the currently asserted y bit (0 when y=0).
- wrap  output  1  one-cycle pulse when a scan step moves from index 2^N-1 to 0.
- done  output  1  one-cycle pulse when the SCAN_ONCE pass completes.
- busy  output  1  high while in SCAN or SCAN_ONCE with e=1.

Behaviour:
- Reset (rst_n low, async): y=0, code=0, wrap=0, done=0, busy=0; state IDLE; index and dwell counters cleared.
- FSM states and entry conditions, evaluated at each clock edge with e=1:
  - IDLE: entered on mode 00.
  - DIRECT: entered on mode 01.
  - SCAN: entered on mode 10.
  - ONCE: entered on mode 11.
  - FIN: entered from ONCE at pass end.
- Mode change: takes effect at the next edge. Index and dwell counter restart at 0. The first scan output appears on the cycle after the change.
- IDLE: y=0, code=0.
- DIRECT:
  - Latency 1. If valid=1 at an edge, y <= 1<<a and code <= a on that edge.
  - With valid=0, y and code hold.
  - On entry, y=0 until the first valid.
- SCAN:
  - y = 1<<index. The dwell counter counts 0..dwell; when it reaches dwell, index increments (mod 2^N) and the counter clears.
  - dwell=0: index advances every cycle.
  - dwell is sampled whenever the counter clears. A change mid-step takes effect at the next step boundary.
  - wrap is asserted in the same cycle y changes from bit 2^N-1 to bit 0.
- ONCE:
  - Same stepping as SCAN, starting at index 0.
  - When the last index (2^N-1) finishes its dwell, the FSM goes to FIN. y=0 and done=1 for that one cycle; wrap is not asserted.
  - FIN holds y=0 until mode changes. Re-entering mode 11 (via any other mode) starts a new pass.
  - If mode stays 11, no restart occurs.
- e=0:
  - Combinationally forces y=0 and busy=0; code holds its last registered value.
  - FSM, index and dwell counter hold; wrap and done are not asserted.
  - When e returns to 1, output resumes at the same index with the same remaining dwell.
  - valid is ignored while e=0.
- Simultaneous events:
  - A mode change in the same cycle as a step boundary: the mode change wins.
  - valid in a non-DIRECT mode: ignored.
- N=1: 2 outputs. Scan alternates 01/10; wrap fires every second step.
- Reset asserted mid-scan: immediate return to reset values; no done pulse.

Decomposition:
- Package decoder_pkg holds:
  - mode encodings (MODE_OFF, MODE_DIRECT, MODE_SCAN, MODE_ONCE);
  - the FSM state enum (IDLE, DIRECT, SCAN, ONCE, FIN);
  - a function onehot(code) returning 1<<code.
- One sub-module, decoder_dwell_timer: DWELL_W counter with load/clear/hold inputs and a step output.
- The top level holds the FSM, index register and output registers.

Test Plan:
- N=2, reset, mode=01, e=1, valid pulses with a=0,1,2,3 on consecutive edges -> y=0001,0010,0100,1000 each one cycle after its strobe; code=0,1,2,3.
- N=2, mode=10, dwell=2 -> y steps 0001,0010,0100,1000,0001 every 3 cycles; wrap high exactly in the cycle y returns to 0001; busy=1.
- N=2, mode=11, dwell=0 -> y=0001,0010,0100,1000 on consecutive cycles, then y=0000 with done=1 for one cycle; y stays 0000 while mode is held at 11.
- Mid-scan (index 2, dwell counter 1 of 3), e=0 for 5 cycles -> y=0000, busy=0, code=2 throughout; on e=1, y=0100 for the 2 remaining cycles, then 1000.
- N=3, mode=10, dwell=0 -> walking one across 8 bits; wrap pulse every 8 cycles. Switch to mode=01 mid-scan with no valid -> y=00000000.
- Assert rst_n low mid-SCAN_ONCE -> y=0, code=0, done never pulses; after release, FSM is in IDLE.
